// File: rtl/kronos_fetch.sv
// Kronos instruction fetch: PC sequencing, bus request handshake and decode-side FIFO.
// Define KRONOS_FETCH_SKID_EN for a 2-entry buffer; otherwise the buffer holds 1 entry.
module kronos_fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    output logic        instr_req,
    input  logic [31:0] instr_data,
    input  logic        instr_ack,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_ir,
    output logic        fetch_vld,
    input  logic        fetch_rdy
);

`ifdef KRONOS_FETCH_SKID_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    typedef enum logic {FETCH, DRAIN} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] redirect, redirect_nxt;
    logic [31:0] q_pc     [DEPTH];
    logic [31:0] q_ir     [DEPTH];
    logic [31:0] q_pc_nxt [DEPTH];
    logic [31:0] q_ir_nxt [DEPTH];
    logic [1:0]  count, count_nxt, wr_idx;
    logic        pop, push, flush;

    assign instr_addr = {pc[31:2], 2'b00};
    assign fetch_vld  = (count != 2'd0);
    assign fetch_pc   = q_pc[0];
    assign fetch_ir   = q_ir[0];
    assign pop        = fetch_vld && fetch_rdy;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        redirect_nxt = redirect;
        instr_req    = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;
        case (state)
            FETCH: begin
                instr_req = rstz && ((count != FULL_CNT) || pop);
                if (branch) begin
                    flush = 1'b1;
                    // An outstanding request cannot be withdrawn; wait it out in DRAIN.
                    if (instr_req && !instr_ack) begin
                        redirect_nxt = branch_target;
                        state_nxt    = DRAIN;
                    end else begin
                        pc_nxt = branch_target;
                    end
                end else if (instr_req && instr_ack) begin
                    push   = 1'b1;
                    pc_nxt = pc + 32'd4;
                end
            end
            DRAIN: begin
                instr_req = rstz;
                if (branch) redirect_nxt = branch_target;
                if (instr_ack) begin
                    pc_nxt    = branch ? branch_target : redirect;
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Shift-down FIFO: head always lives in entry 0.
    always_comb begin
        wr_idx = count - {1'b0, pop};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            q_pc_nxt[i] = pop ? q_pc[(i + 1) % DEPTH] : q_pc[i];
            q_ir_nxt[i] = pop ? q_ir[(i + 1) % DEPTH] : q_ir[i];
            if (push && (2'(i) == wr_idx)) begin
                q_pc_nxt[i] = {pc[31:2], 2'b00};
                q_ir_nxt[i] = instr_data;
            end
        end
        count_nxt = flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state    <= FETCH;
            pc       <= BOOT_ADDR;
            redirect <= '0;
            count    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_pc[i] <= '0;
                q_ir[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            redirect <= redirect_nxt;
            count    <= count_nxt;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_pc[i] <= q_pc_nxt[i];
                q_ir[i] <= q_ir_nxt[i];
            end
        end
    end

endmodule
